// File: rtl/count_stream_checker.sv
// count_stream_checker: predicts a loadable up-counter's next output, locks onto the stream
// and flags deviations with a mismatch pulse and a saturating lock-loss count.
module count_stream_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_THRESH = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_reset,
    input  logic             S,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] q,
    input  logic             clear_err,
    output logic [WIDTH-1:0] expected,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {UNSYNC = 2'b00, TRACK = 2'b01, ERROR = 2'b10} state_t;

    state_t           state_q, state_d;
    logic             p_rst_q, p_s_q, p_valid_q;
    logic [WIDTH-1:0] p_d_q, p_q_q, expected_q, expected_d, pred;
    logic [2:0]       match_q, match_d, match_inc;
    logic             mismatch_q, mismatch_d, wrap_q, wrap_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             hit, miss, relock, err_inc;

    always_comb begin
        pred       = p_rst_q ? '0 : p_s_q ? p_d_q : p_q_q + WIDTH'(1);
        hit        = p_valid_q && (q == pred);
        miss       = p_valid_q && !hit;
        match_inc  = match_q + 3'd1;
        relock     = hit && (match_inc == 3'(LOCK_THRESH));
        state_d    = (state_q == TRACK) ? (miss ? ERROR : TRACK)
                   : relock ? TRACK
                   : (state_q == ERROR) ? ERROR : UNSYNC;
        // match_cnt restarts on any miss and on every state change
        match_d    = (!hit || state_d != state_q || state_q == TRACK) ? '0 : match_inc;
        mismatch_d = miss && (state_q == TRACK || state_q == ERROR);
        wrap_d     = hit && state_q == TRACK && !p_rst_q && !p_s_q && p_q_q == '1 && q == '0;
        err_inc    = miss && state_q == TRACK && err_q != '1;
        err_d      = clear_err ? '0 : err_q + ERR_W'(err_inc);
        expected_d = cnt_reset ? '0 : S ? D : q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNSYNC;
            p_rst_q    <= 1'b0;
            p_s_q      <= 1'b0;
            p_d_q      <= '0;
            p_q_q      <= '0;
            p_valid_q  <= 1'b0;
            match_q    <= '0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            p_rst_q    <= cnt_reset;
            p_s_q      <= S;
            p_d_q      <= D;
            p_q_q      <= q;
            p_valid_q  <= 1'b1;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            expected_q <= expected_d;
        end
    end

    assign expected  = expected_q;
    assign locked    = (state_q == TRACK);
    assign mismatch  = mismatch_q;
    assign wrap      = wrap_q;
    assign err_count = err_q;
    assign state     = state_q;
endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker: table-driven vectors with a scoreboard queue for count_stream_checker.
module tb_count_stream_checker;
    localparam logic [1:0] U = 2'b00, T = 2'b01, ER = 2'b10;

    typedef struct {
        logic       cr, s;
        logic [3:0] d, qv;
        logic       clr;
        logic [3:0] ex;
        logic       mm, wr;
        logic [7:0] err;
        logic [1:0] st;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b1, cnt_reset = 1'b0, S = 1'b0, clear_err = 1'b0;
    logic [3:0] D = '0, q = '0, expected;
    logic       locked, mismatch, wrap;
    logic [7:0] err_count;
    logic [1:0] state;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0, n_fail = 0;

    count_stream_checker dut (
        .clk(clk), .reset(reset), .cnt_reset(cnt_reset), .S(S), .D(D), .q(q),
        .clear_err(clear_err), .expected(expected), .locked(locked), .mismatch(mismatch),
        .wrap(wrap), .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    function automatic vec_t mk(logic cr, logic s, logic [3:0] d, logic [3:0] qv, logic clr,
                                logic [3:0] ex, logic mm, logic wr, logic [7:0] err, logic [1:0] st);
        vec_t v;
        v.cr = cr; v.s = s; v.d = d; v.qv = qv; v.clr = clr;
        v.ex = ex; v.mm = mm; v.wr = wr; v.err = err; v.st = st;
        return v;
    endfunction

    task automatic check(string name, logic [3:0] ex, logic mm, logic wr, logic [7:0] err, logic [1:0] st);
        n_vec++;
        if (expected !== ex || locked !== (st == T) || mismatch !== mm || wrap !== wr ||
            err_count !== err || state !== st) begin
            n_fail++;
            $display("FAIL %s: got exp=%h lock=%b mm=%b wrap=%b err=%0d st=%b, want exp=%h lock=%b mm=%b wrap=%b err=%0d st=%b",
                     name, expected, locked, mismatch, wrap, err_count, state,
                     ex, st == T, mm, wr, err, st);
        end
    endtask

    task automatic apply(int i);
        vec_t e;
        cnt_reset = tbl[i].cr; S = tbl[i].s; D = tbl[i].d; q = tbl[i].qv; clear_err = tbl[i].clr;
        sb.push_back(tbl[i]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d", i), e.ex, e.mm, e.wr, e.err, e.st);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 check("async_reset", 4'h0, 1'b0, 1'b0, 8'd0, U);
        #2 reset = 1'b0;
    endtask

    initial begin
        //               cr s  d     q     clr  exp   mm wr err st
        // sync and count
        tbl.push_back(mk(0, 1, 4'h7, 4'h0, 0,   4'h7, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h7, 0,   4'h8, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h8, 0,   4'h9, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h9, 0,   4'hA, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'hA, 0,   4'hB, 0, 0, 0, T));
        // reload while tracking
        tbl.push_back(mk(0, 1, 4'h4, 4'hB, 0,   4'h4, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h4, 0,   4'h5, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h5, 0,   4'h6, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h6, 0,   4'h7, 0, 0, 0, T));
        // wrap
        tbl.push_back(mk(0, 1, 4'hE, 4'h7, 0,   4'hE, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'hE, 0,   4'hF, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'hF, 0,   4'h0, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0,   4'h1, 0, 1, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h1, 0,   4'h2, 0, 0, 0, T));
        // fault injection, relock, second fault with a repeated miss in ERROR
        tbl.push_back(mk(0, 1, 4'h5, 4'h2, 0,   4'h5, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h5, 0,   4'h6, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h9, 0,   4'hA, 1, 0, 1, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'hA, 0,   4'hB, 0, 0, 1, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'hB, 0,   4'hC, 0, 0, 1, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'hC, 0,   4'hD, 0, 0, 1, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h3, 0,   4'h4, 1, 0, 2, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h7, 0,   4'h8, 1, 0, 2, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h8, 0,   4'h9, 0, 0, 2, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h9, 0,   4'hA, 0, 0, 2, T));
        // counter reset, then cnt_reset and S together
        tbl.push_back(mk(0, 1, 4'hA, 4'hA, 0,   4'hA, 0, 0, 2, T));
        tbl.push_back(mk(1, 0, 4'h0, 4'hA, 0,   4'h0, 0, 0, 2, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0,   4'h1, 0, 0, 2, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h1, 0,   4'h2, 0, 0, 2, T));
        tbl.push_back(mk(1, 1, 4'h9, 4'h2, 0,   4'h0, 0, 0, 2, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0,   4'h1, 0, 0, 2, T));
        // clear_err beats a same-edge increment, then clear on its own
        tbl.push_back(mk(0, 0, 4'h0, 4'h7, 1,   4'h8, 1, 0, 0, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h8, 0,   4'h9, 0, 0, 0, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h9, 0,   4'hA, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h5, 0,   4'h6, 1, 0, 1, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h6, 1,   4'h7, 0, 0, 0, ER));
        tbl.push_back(mk(0, 0, 4'h0, 4'h7, 0,   4'h8, 0, 0, 0, T));
        tbl.push_back(mk(0, 0, 4'h0, 4'h2, 0,   4'h3, 1, 0, 1, ER));
        // after mid-stream reset: capture edge plus two hits
        tbl.push_back(mk(0, 0, 4'h0, 4'h3, 0,   4'h4, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h4, 0,   4'h5, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h5, 0,   4'h6, 0, 0, 0, T));
        // misses while UNSYNC: silent, and they restart the hit count
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0,   4'h1, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h5, 0,   4'h6, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h6, 0,   4'h7, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h8, 0,   4'h9, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'h9, 0,   4'hA, 0, 0, 0, U));
        tbl.push_back(mk(0, 0, 4'h0, 4'hA, 0,   4'hB, 0, 0, 0, T));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'h0, 1'b0, 1'b0, 8'd0, U);
        reset = 1'b0;
        for (int i = 0; i < 37; i++) apply(i);
        pulse_reset();
        for (int i = 37; i < 40; i++) apply(i);
        pulse_reset();
        for (int i = 40; i < tbl.size(); i++) apply(i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/count_stream_checker.md
# count_stream_checker

Receive-side monitor for the four-bit loadable up-counter. It samples the counter's load strobe, load value, reset and output on every clock and predicts each next output value. It then locks onto the count stream and flags any deviation with a pulse and a saturating error count. It sits beside the counter in the lab top level and in self-checking benches.

## Interface
Parameters:
- WIDTH, 4, counter data width (q, D, expected)
- LOCK_THRESH, 2, consecutive correct predictions needed to enter TRACK (legal range 1..7)
- ERR_W, 8, width of err_count

Ports:
- clk  in  1  single system clock; all sampling on the rising edge
- reset  in  1  checker reset; asynchronous, active-high
- cnt_reset  in  1  counter's own reset as driven to the counter; sampled synchronously
- S  in  1  counter load select (1 = load D on the edge)
- D  in  WIDTH  counter load value
- q  in  WIDTH  counter output under observation
- clear_err  in  1  synchronous clear of err_count
- expected  out  WIDTH  predicted value of q at the next sample
- locked  out  1  high while in TRACK
- mismatch  out  1  one-cycle pulse, registered
- wrap  out  1  one-cycle pulse on a correctly predicted count wrap from all-ones to 0
- err_count  out  ERR_W  number of lock losses, saturating
- state  out  2  00 UNSYNC, 01 TRACK, 10 ERROR

## Operation
- Counter model: on each edge, cnt_reset=1 gives 0; else S=1 gives D; else q+1 mod 2^WIDTH. cnt_reset has priority over S.
- Registers p_rst, p_S, p_D, p_q, p_valid capture cnt_reset, S, D and q on every edge.
- pred = p_rst ? 0 : p_S ? p_D : p_q+1, truncated to WIDTH.
- hit = (q == pred). The comparison is evaluated only when p_valid=1.
- match_cnt counts consecutive hits. It clears on any miss and on every state change.
- UNSYNC:
  - Entered from reset. The first edge only sets p_valid.
  - A miss clears match_cnt. No mismatch pulse and no error count.
  - When match_cnt reaches LOCK_THRESH, go to TRACK.
- TRACK:
  - On a miss: go to ERROR, pulse mismatch, and increment err_count (saturating at all-ones).
  - On a hit with p_rst=0, p_S=0, p_q=all-ones and q=0: pulse wrap.
- ERROR:
  - Every miss pulses mismatch. err_count does not increment, so one count is recorded per lock loss.
  - When match_cnt reaches LOCK_THRESH, go to TRACK.
- clear_err=1 zeroes err_count on the edge. If an increment occurs on the same edge, the clear wins.
- A load or counter reset is never a mismatch when the matching S or cnt_reset was sampled on the previous edge.

## Timing
- Reset values: state=UNSYNC, p_valid=0, match_cnt=0, expected=0, locked=0, mismatch=0, wrap=0, err_count=0.
- Latency:
  - q is sampled at edge k and compared against the prediction made from edge k-1.
  - mismatch, wrap, locked and state update at edge k and are visible in the cycle that follows.
- expected is registered at edge k. It equals the prediction for the q sample at edge k+1.
- Minimum time to lock from reset is 1 + LOCK_THRESH edges. With the default LOCK_THRESH=2, locked rises after edge 3.
- Re-lock after a lock loss takes LOCK_THRESH consecutive hits.
- Asserting reset mid-stream drops all outputs to their reset values immediately, without waiting for a clock edge.
- Release of reset is synchronous to clk. The first edge after release is the capture-only edge.
- If S and cnt_reset are sampled high on the same edge, the prediction is 0.
- Inputs must be stable around the rising edge. The checker samples the same edge the counter uses, so q seen at edge k is the value produced at edge k-1.

## Test plan
- Sync and count: reset, then S=1, D=7 for one cycle, then S=0 with q following 7, 8, 9, A. Required: locked=1 by the third compare and expected=B after q=A is sampled.
- Reload while tracking: S=1, D=4 for one cycle, then q=4, 5, 6. Required: no mismatch, locked stays 1, expected=7 after q=6 is sampled.
- Wrap: load E, then q=E, F, 0, 1. Required: a single wrap pulse in the cycle after q=0 is sampled, and no mismatch.
- Fault injection: while tracking at q=5, force q=9 instead of 6 for one cycle. Required:
  - one mismatch pulse, state=ERROR, locked=0, err_count=1.
  - Feeding 10 then 11 (decimal) restores TRACK.
  - A second fault then gives err_count=2.
- Counter reset: cnt_reset=1 for one cycle while q=A, then q=0, 1. Required: no mismatch and lock held.
- Checker reset mid-stream: assert reset for 3 ns between edges. Required: state, locked, mismatch and err_count read 0 immediately, and re-lock takes 3 edges. Also check that clear_err=1 zeroes err_count on the edge.
